// File: rtl/i2c_reg_slave.sv
// Write-only I2C register slave: START, device address, sub-address byte, data byte, STOP.
// Produces a one-cycle strobe with the sub-address/data pair; reads are NACKed and flagged as errors.
module i2c_reg_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h1A
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iI2C_SCLK,
  input  logic       iI2C_SDAT,
  output logic       oSDA_OE,
  output logic       oWR_STB,
  output logic [7:0] oWR_SUB,
  output logic [7:0] oWR_DATA,
  output logic       oBUSY,
  output logic       oERR
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_SUB, S_SUB_ACK, S_DATA, S_DATA_ACK, S_IGNORE
  } state_t;

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_hist_q, sda_hist_q;

  // Synchronizers keep running through reset so edge history is valid once reset lifts.
  always_ff @(posedge iCLK) begin
    scl_sync_q <= {scl_sync_q[0], iI2C_SCLK};
    sda_sync_q <= {sda_sync_q[0], iI2C_SDAT};
    scl_hist_q <= scl_sync_q[1];
    sda_hist_q <= sda_sync_q[1];
  end

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
  assign scl_s     = scl_sync_q[1];
  assign sda_s     = sda_sync_q[1];
  assign scl_rise  = scl_s & ~scl_hist_q;
  assign scl_fall  = ~scl_s & scl_hist_q;
  assign start_det = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
  assign stop_det  = scl_s & scl_hist_q & ~sda_hist_q & sda_s;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] sub_q, sub_d;
  logic [7:0] wr_sub_q, wr_sub_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       oe_q, oe_d;
  logic       stb_q, stb_d;
  logic       err_q, err_d;
  logic       mism_q, mism_d;
  logic [7:0] byte_nxt;

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      sub_q     <= '0;
      wr_sub_q  <= '0;
      wr_data_q <= '0;
      oe_q      <= 1'b0;
      stb_q     <= 1'b0;
      err_q     <= 1'b0;
      mism_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      sub_q     <= sub_d;
      wr_sub_q  <= wr_sub_d;
      wr_data_q <= wr_data_d;
      oe_q      <= oe_d;
      stb_q     <= stb_d;
      err_q     <= err_d;
      mism_q    <= mism_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    sub_d     = sub_q;
    wr_sub_d  = wr_sub_q;
    wr_data_d = wr_data_q;
    oe_d      = oe_q;
    mism_d    = mism_q;
    stb_d     = 1'b0;
    err_d     = 1'b0;
    byte_nxt  = {shift_q[6:0], sda_s};

    // Bus conditions win over any bit event seen in the same cycle.
    if (start_det || stop_det) begin
      err_d   = (state_q == S_SUB) || (state_q == S_SUB_ACK) || (state_q == S_DATA);
      state_d = start_det ? S_ADDR : S_IDLE;
      cnt_d   = '0;
      oe_d    = 1'b0;
      mism_d  = 1'b0;
    end else begin
      case (state_q)
        S_ADDR, S_SUB, S_DATA: begin
          if (scl_rise) begin
            shift_d = byte_nxt;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (state_q == S_ADDR) begin
                if (byte_nxt[7:1] != SLAVE_ADDR) begin
                  state_d = S_IGNORE;
                  mism_d  = 1'b1;
                end else if (byte_nxt[0]) begin
                  state_d = S_IGNORE;
                  err_d   = 1'b1;
                end else begin
                  state_d = S_ADDR_ACK;
                end
              end else if (state_q == S_SUB) begin
                sub_d   = byte_nxt;
                state_d = S_SUB_ACK;
              end else begin
                wr_sub_d  = sub_q;
                wr_data_d = byte_nxt;
                stb_d     = 1'b1;
                state_d   = S_DATA_ACK;
              end
            end
          end
        end
        // First falling edge drives the ACK, the next one (after the 9th rise) releases it.
        S_ADDR_ACK, S_SUB_ACK, S_DATA_ACK: begin
          if (scl_fall) begin
            oe_d = !oe_q;
            if (oe_q) begin
              state_d = (state_q == S_ADDR_ACK) ? S_SUB :
                        (state_q == S_SUB_ACK)  ? S_DATA : S_IGNORE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign oSDA_OE  = oe_q;
  assign oWR_STB  = stb_q;
  assign oWR_SUB  = wr_sub_q;
  assign oWR_DATA = wr_data_q;
  assign oERR     = err_q;
  assign oBUSY    = (state_q != S_IDLE) && !((state_q == S_IGNORE) && mism_q);

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Bench for i2c_reg_slave: bit-banged I2C master, transaction-level reference model.
module tb_i2c_reg_slave;
  localparam int Q = 60;
  localparam int T = 120;
  localparam int START = -1;
  localparam int STOP  = -2;
  localparam logic [6:0] SLAVE   = 7'h1A;
  localparam logic [7:0] WR_BYTE = {SLAVE, 1'b0};
  localparam logic [7:0] RD_BYTE = {SLAVE, 1'b1};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic sda_oe, wr_stb, busy, err;
  logic [7:0] wr_sub, wr_data;
  logic sda_bus;
  assign sda_bus = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_reg_slave #(.SLAVE_ADDR(SLAVE)) dut (
    .iCLK(clk), .iRST_N(rst_n), .iI2C_SCLK(scl_m), .iI2C_SDAT(sda_bus),
    .oSDA_OE(sda_oe), .oWR_STB(wr_stb), .oWR_SUB(wr_sub), .oWR_DATA(wr_data),
    .oBUSY(busy), .oERR(err)
  );

  int total = 0;
  int bad = 0;

  // Cumulative monitors; the driver diffs snapshots taken around each transaction.
  int stb_n = 0, err_n = 0, oe_n = 0;
  logic [15:0] stb_log [0:1023];
  always @(negedge clk) begin
    if (wr_stb) begin
      stb_log[stb_n % 1024] = {wr_sub, wr_data};
      stb_n = stb_n + 1;
    end
    if (err) err_n = err_n + 1;
    if (sda_oe) oe_n = oe_n + 1;
  end

  int tx[$];
  bit obs_ack[$], obs_drv[$], obs_busy[$];
  bit exp_ack[$], exp_busy[$];
  logic [15:0] exp_stb[$];
  int exp_err;
  logic [15:0] last_wr = 16'h0000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    if (scl_m) begin
      sda_m = 1'b1; #Q; sda_m = 1'b0; #T; scl_m = 1'b0; #Q;
    end else begin
      sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; sda_m = 1'b0; #Q; scl_m = 1'b0; #Q;
    end
  endtask

  task automatic do_stop();
    sda_m = 1'b0; #Q; scl_m = 1'b1; #Q; sda_m = 1'b1; #T;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n, output bit drv);
    drv = 1'b0;
    for (int i = 7; i > 7 - n; i--) begin
      sda_m = b[i]; #Q;
      scl_m = 1'b1; #Q;
      if (sda_oe) drv = 1'b1;
      #Q; scl_m = 1'b0; #Q;
    end
  endtask

  task automatic ack_bit(output bit a);
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    a = ~sda_bus;
    #Q; scl_m = 1'b0; #Q;
  endtask

  // Reference: per START-delimited segment, decide acks/strobe/error from byte count and address.
  task automatic model_tx();
    logic [7:0] seg[$];
    bit open;
    open = 1'b0;
    exp_ack.delete(); exp_busy.delete(); exp_stb.delete(); exp_err = 0;
    foreach (tx[k]) begin
      if (tx[k] < 0) begin
        if (open) begin
          exp_busy.push_back(!(seg.size() > 0 && seg[0][7:1] != SLAVE));
          if (seg.size() > 0 && seg[0] == RD_BYTE) exp_err++;
          if (seg.size() > 0 && seg[0] == WR_BYTE) begin
            if (seg.size() < 3) exp_err++;
            else begin
              exp_stb.push_back({seg[1], seg[2]});
              last_wr = {seg[1], seg[2]};
            end
          end
        end
        seg.delete();
        open = (tx[k] == START);
      end else begin
        exp_ack.push_back(open && seg.size() < 3 &&
                          ((seg.size() == 0) ? 8'(tx[k]) : seg[0]) == WR_BYTE);
        seg.push_back(8'(tx[k]));
      end
    end
  endtask

  task automatic drive_tx();
    bit open, d, a;
    open = 1'b0;
    foreach (tx[k]) begin
      if (tx[k] < 0) begin
        if (open) obs_busy.push_back(busy);
        if (tx[k] == START) do_start(); else do_stop();
        open = (tx[k] == START);
      end else begin
        send_bits(8'(tx[k]), 8, d);
        ack_bit(a);
        obs_drv.push_back(d);
        obs_ack.push_back(a);
      end
    end
  endtask

  task automatic run_and_check(input string name);
    int s0, e0, o0, drv_cnt, nack;
    s0 = stb_n; e0 = err_n; o0 = oe_n;
    model_tx();
    obs_ack.delete(); obs_drv.delete(); obs_busy.delete();
    drive_tx();
    #T;
    drv_cnt = 0; nack = 0;
    foreach (obs_drv[i]) drv_cnt += int'(obs_drv[i]);
    foreach (exp_ack[i]) begin
      nack += int'(exp_ack[i]);
      check($sformatf("%s ack%0d", name, i), 32'(obs_ack[i]), 32'(exp_ack[i]));
    end
    check({name, " sda_drive_in_data_bits"}, drv_cnt, 0);
    check({name, " oe_seen"}, 32'(oe_n != o0), 32'(nack != 0));
    foreach (exp_busy[i])
      check($sformatf("%s busy_seg%0d", name, i), 32'(obs_busy[i]), 32'(exp_busy[i]));
    check({name, " strobe_count"}, stb_n - s0, exp_stb.size());
    foreach (exp_stb[i])
      check($sformatf("%s strobe%0d sub_data", name, i), 32'(stb_log[(s0 + i) % 1024]), 32'(exp_stb[i]));
    check({name, " err_pulses"}, err_n - e0, exp_err);
    check({name, " held_sub_data"}, 32'({wr_sub, wr_data}), 32'(last_wr));
    check({name, " busy_after_stop"}, 32'(busy), 0);
    check({name, " oe_after_stop"}, 32'(sda_oe), 0);
  endtask

  initial begin
    int s0, e0, o0, nseg, nb;
    bit d, a;
    logic [7:0] ab;

    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    check("reset oe", 32'(sda_oe), 0);
    check("reset stb", 32'(wr_stb), 0);
    check("reset err", 32'(err), 0);
    check("reset busy", 32'(busy), 0);
    check("reset sub", 32'(wr_sub), 0);
    check("reset data", 32'(wr_data), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    tx = '{START, 'h34, 'h0C, 'h00, STOP};
    run_and_check("normal_write");
    tx = '{START, 'h40, 'h15, 'h00, STOP};
    run_and_check("wrong_addr");
    tx = '{START, 'h35, STOP};
    run_and_check("read_attempt");
    tx = '{START, 'h34, 'h12, STOP};
    run_and_check("truncated");
    tx = '{START, 'h34, 'h0E, START, 'h34, 'h10, 'h0E, STOP};
    run_and_check("repeated_start");
    tx = '{START, 'h34, 'h21, 'h5A, 'h77, 'h88, STOP};
    run_and_check("extra_bytes");

    // Reset in the middle of the data byte, then let the master finish the byte and stop.
    s0 = stb_n; e0 = err_n;
    do_start();
    send_bits(8'h34, 8, d); ack_bit(a);
    send_bits(8'h12, 8, d); ack_bit(a);
    send_bits(8'hA5, 4, d);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midreset oe", 32'(sda_oe), 0);
    check("midreset stb", 32'(wr_stb), 0);
    check("midreset err", 32'(err), 0);
    check("midreset busy", 32'(busy), 0);
    check("midreset sub", 32'(wr_sub), 0);
    check("midreset data", 32'(wr_data), 0);
    rst_n = 1'b1;
    last_wr = 16'h0000;
    repeat (2) @(negedge clk);
    o0 = oe_n;
    send_bits(8'h50, 4, d); ack_bit(a);
    check("after_reset ack", 32'(a), 0);
    do_stop();
    check("after_reset oe_seen", oe_n - o0, 0);
    check("after_reset strobes", stb_n - s0, 0);
    check("after_reset err", err_n - e0, 0);
    tx = '{START, 'h34, 'h12, 'h01, STOP};
    run_and_check("post_reset_write");

    for (int r = 0; r < 15; r++) begin
      tx.delete();
      nseg = $urandom_range(1, 2);
      for (int s = 0; s < nseg; s++) begin
        tx.push_back(START);
        case ($urandom_range(0, 3))
          0, 1:    ab = WR_BYTE;
          2:       ab = RD_BYTE;
          default: ab = 8'($urandom_range(0, 255));
        endcase
        tx.push_back(int'(ab));
        nb = $urandom_range(0, 3);
        for (int b = 0; b < nb; b++) tx.push_back(int'($urandom_range(0, 255)));
      end
      tx.push_back(STOP);
      run_and_check($sformatf("rand%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/i2c_reg_slave.md
I2C_REG_SLAVE -- requirements
Module: i2c_reg_slave

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h1A, the 7-bit I2C device address to acknowledge (wire byte 8'h34 for write).
REQ-002 SHALL have port iCLK, input, 1, the single system clock for all logic.
REQ-003 SHALL have port iRST_N, input, 1, reset; synchronous, active-low.
REQ-004 SHALL have port iI2C_SCLK, input, 1, I2C clock from the bus, asynchronous to iCLK.
REQ-005 SHALL have port iI2C_SDAT, input, 1, I2C data from the bus, asynchronous to iCLK.
REQ-006 SHALL have port oSDA_OE, output, 1; 1 means pull SDA low (ACK), 0 means release.
REQ-007 SHALL have port oWR_STB, output, 1, one-cycle pulse when a complete register write is received.
REQ-008 SHALL have port oWR_SUB, output, 8, received sub-address byte, valid while oWR_STB is high and held afterwards.
REQ-009 SHALL have port oWR_DATA, output, 8, received data byte, valid while oWR_STB is high and held afterwards.
REQ-010 SHALL have port oBUSY, output, 1, high from an addressed START until STOP or return to IDLE.
REQ-011 SHALL have port oERR, output, 1, one-cycle pulse on a protocol error (REQ-022, REQ-023).

Function
REQ-012 SHALL pass iI2C_SCLK and iI2C_SDAT through 2-flop synchronizers, then one history flop, and detect all edges from synchronized values only.
REQ-013 SHALL detect START on SDA falling while SCL is high, and STOP on SDA rising while SCL is high.
REQ-014 SHALL support iCLK of at least 20x SCL frequency; behaviour below that ratio is undefined.
REQ-015 SHALL implement states IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, DATA, DATA_ACK and IGNORE.
REQ-016 SHALL enter ADDR on START from any state, including a repeated START; the bit counter SHALL clear to 0.
REQ-017 SHALL shift SDA MSB-first on each SCL rising edge in ADDR, SUB and DATA, and leave the state after the 8th bit.
REQ-018 SHALL, in ADDR, on address match with R/W=0, go to ADDR_ACK and then SUB; on mismatch it SHALL go to IGNORE with no ACK and no oERR.
REQ-019 SHALL assert oSDA_OE in an ACK state from the first SCL falling edge after the 8th rising edge, hold it through the 9th rising edge, and release it on the following falling edge.
REQ-020 SHALL go SUB -> SUB_ACK -> DATA -> DATA_ACK -> IGNORE, acknowledging the sub-address and data bytes.
REQ-021 SHALL register oWR_SUB/oWR_DATA and pulse oWR_STB for exactly one iCLK cycle, in the cycle after the 8th data-bit SCL rising edge is detected; no strobe SHALL occur in any other case.
REQ-022 SHALL, on address match with R/W=1, withhold ACK (NACK), go to IGNORE and pulse oERR; a read SHALL NOT be supported.
REQ-023 SHALL pulse oERR and suppress oWR_STB if STOP or START arrives in SUB, SUB_ACK or DATA (write incomplete).
REQ-024 SHALL leave extra bytes after DATA_ACK unacknowledged (IGNORE); no second strobe SHALL be generated.
REQ-025 SHALL return to IDLE from any state on STOP, releasing oSDA_OE in the same cycle.
REQ-026 SHALL hold oBUSY high in all states except IDLE and IGNORE-after-mismatch.
REQ-027 SHALL give START/STOP priority over a bit-shift event detected in the same cycle.

Reset
REQ-028 SHALL, with iRST_N low at a rising iCLK edge, enter IDLE, clear the bit counter and shift register, and set oSDA_OE=0, oWR_STB=0, oERR=0, oBUSY=0, oWR_SUB=8'h00 and oWR_DATA=8'h00.
REQ-029 SHALL, after reset released mid-transfer, ignore bus activity until the next START.

Verification
REQ-030 SHALL verify a normal write: START, 0x34, 0x0C, 0x00, STOP -> three ACKs, one oWR_STB with SUB=0x0C and DATA=0x00, oERR=0.
REQ-031 SHALL verify a wrong address: START, 0x40, 0x15, 0x00, STOP -> oSDA_OE never 1, no strobe, no oERR, oBUSY=0.
REQ-032 SHALL verify a read attempt: START, 0x35 -> 9th bit NACK, oERR one pulse, no strobe.
REQ-033 SHALL verify a truncated write: START, 0x34, 0x12, STOP -> two ACKs, oERR one pulse, no strobe, IDLE.
REQ-034 SHALL verify a repeated START: START, 0x34, 0x0E, START, 0x34, 0x10, 0x0E, STOP -> oERR once, one strobe SUB=0x10 DATA=0x0E.
REQ-035 SHALL verify reset mid-DATA byte (after 4 bits): all outputs return to reset values; the next full write of 0x34/0x12/0x01 strobes correctly.
